// File: rtl/hazard_scoreboard.sv
// Hazard control for a 5-stage pipeline: per-register shift scoreboard driving stall/flush and E forward selects.
// Optional forwarding path enabled by defining HAZARD_FORWARD_EN (requires WB_DIST==3).

module hazard_sb_entry #(
  parameter int WB_DIST = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set,
  input  logic               set_ld,
  input  logic               kill,
  output logic [WB_DIST-1:1] pend,
  output logic [WB_DIST-1:1] ld
);
  logic [WB_DIST-1:1] pend_keep, ld_keep, pend_nxt, ld_nxt;

  // Wrong-path writer (top bit = in E) is dropped before the shift.
  always_comb begin
    pend_keep = pend;
    ld_keep   = ld;
    if (kill) begin
      pend_keep[WB_DIST-1] = 1'b0;
      ld_keep[WB_DIST-1]   = 1'b0;
    end
    pend_nxt              = pend_keep >> 1;
    ld_nxt                = ld_keep >> 1;
    pend_nxt[WB_DIST-1]   = set;
    ld_nxt[WB_DIST-1]     = set & set_ld;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      ld   <= '0;
    end else begin
      pend <= pend_nxt;
      ld   <= ld_nxt;
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int REG_SIZE = 5,
  parameter int WB_DIST  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validD,
  input  logic [REG_SIZE-1:0] rs1D,
  input  logic [REG_SIZE-1:0] rs2D,
  input  logic                useRs1D,
  input  logic                useRs2D,
  input  logic [REG_SIZE-1:0] rdD,
  input  logic                regWriteD,
  input  logic                mem2regD,
  input  logic                PCSrcM,
  output logic                stallF,
  output logic                stallD,
  output logic                flushD,
  output logic                flushE,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic                busy
);
  logic [NREGS-1:0][WB_DIST-1:1] pend, ld;
  logic haz1, haz2, stall_raw, issue;
  logic unused_ld;

  assign pend[0] = '0;
  assign ld[0]   = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    hazard_sb_entry #(.WB_DIST(WB_DIST)) u_entry (
      .clk    (clk),
      .reset  (reset),
      .set    (issue & regWriteD & (rdD == REG_SIZE'(r))),
      .set_ld (mem2regD),
      .kill   (PCSrcM),
      .pend   (pend[r]),
      .ld     (ld[r])
    );
  end

  assign haz1 = validD & useRs1D & (rs1D != '0);
  assign haz2 = validD & useRs2D & (rs2D != '0);

`ifdef HAZARD_FORWARD_EN
  if (WB_DIST != 3) begin : g_bad_dist
    $error("HAZARD_FORWARD_EN requires WB_DIST == 3");
  end

  logic [1:0] sel1, sel2;

  // Only a load sitting in E cannot be forwarded in time.
  assign stall_raw = (haz1 & pend[rs1D][2] & ld[rs1D][2]) |
                     (haz2 & pend[rs2D][2] & ld[rs2D][2]);

  // Youngest writer wins: E (bit 2) before M (bit 1).
  always_comb begin
    sel1 = 2'b00;
    sel2 = 2'b00;
    if (haz1) begin
      if (pend[rs1D][2])      sel1 = 2'b10;
      else if (pend[rs1D][1]) sel1 = 2'b01;
    end
    if (haz2) begin
      if (pend[rs2D][2])      sel2 = 2'b10;
      else if (pend[rs2D][1]) sel2 = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !issue) begin
      forwardAE <= 2'b00;
      forwardBE <= 2'b00;
    end else begin
      forwardAE <= sel1;
      forwardBE <= sel2;
    end
  end
`else
  // Interlock until the writer reaches the regfile write-through.
  assign stall_raw = (haz1 & (|pend[rs1D])) | (haz2 & (|pend[rs2D]));
  assign forwardAE = 2'b00;
  assign forwardBE = 2'b00;
`endif

  assign unused_ld = ^ld;

  // A taken branch overrides any stall; reset silences everything.
  assign issue  = validD & ~stall_raw & ~PCSrcM & ~reset;
  assign stallF = stall_raw & ~PCSrcM & ~reset;
  assign stallD = stall_raw & ~PCSrcM & ~reset;
  assign flushD = PCSrcM & ~reset;
  assign flushE = (PCSrcM | stall_raw) & ~reset;
  assign busy   = (|pend) & ~reset;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + random bench for hazard_scoreboard against an in-flight-writer list model.
// Forward selects are queued when the D instruction is evaluated and compared the following cycle.

module tb_hazard_scoreboard;
  localparam int NREGS = 32, RS = 5, WB = 3;

  logic clk = 1'b0;
  logic reset, validD, useRs1D, useRs2D, regWriteD, mem2regD, PCSrcM;
  logic [RS-1:0] rs1D, rs2D, rdD;
  logic stallF, stallD, flushD, flushE, busy;
  logic [1:0] forwardAE, forwardBE;

  hazard_scoreboard #(.NREGS(NREGS), .REG_SIZE(RS), .WB_DIST(WB)) dut (
    .clk(clk), .reset(reset), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .useRs1D(useRs1D), .useRs2D(useRs2D), .rdD(rdD), .regWriteD(regWriteD),
    .mem2regD(mem2regD), .PCSrcM(PCSrcM), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  typedef struct { logic [RS-1:0] rd; bit ld; int age; } wr_t;
  wr_t infl[$];
  logic [1:0] fq_a[$], fq_b[$];

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int youngest(input logic [RS-1:0] r);
    int y = 0;
    foreach (infl[i]) if (infl[i].rd == r && infl[i].age > y) y = infl[i].age;
    return y;
  endfunction

  function automatic bit load_in_e(input logic [RS-1:0] r);
    foreach (infl[i]) if (infl[i].rd == r && infl[i].age == WB-1 && infl[i].ld) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fsel(input bit h, input logic [RS-1:0] r);
`ifdef HAZARD_FORWARD_EN
    int y = youngest(r);
    if (!h) return 2'b00;
    if (y == 2) return 2'b10;
    if (y == 1) return 2'b01;
    return 2'b00;
`else
    return (h && r == '1) ? 2'b00 : 2'b00;
`endif
  endfunction

  task automatic pop_fwd();
    if (fq_a.size() > 0) begin
      check("fwdA", forwardAE, fq_a.pop_front());
      check("fwdB", forwardBE, fq_b.pop_front());
    end
  endtask

  task automatic step(input bit v, input logic [RS-1:0] r1, input bit u1,
                      input logic [RS-1:0] r2, input bit u2, input logic [RS-1:0] rd,
                      input bit rw, input bit isld, input bit pc, output bit stalled);
    bit h1, h2, s, iss;
    wr_t nq[$];
    @(negedge clk);
    reset = 0; validD = v; rs1D = r1; useRs1D = u1; rs2D = r2; useRs2D = u2;
    rdD = rd; regWriteD = rw; mem2regD = isld; PCSrcM = pc;
    #1;
    h1 = v && u1 && r1 != 0;
    h2 = v && u2 && r2 != 0;
`ifdef HAZARD_FORWARD_EN
    s = (h1 && load_in_e(r1)) || (h2 && load_in_e(r2));
`else
    s = (h1 && youngest(r1) > 0) || (h2 && youngest(r2) > 0);
`endif
    iss = v && !s && !pc;
    check("stallF", {1'b0, stallF}, {1'b0, s && !pc});
    check("stallD", {1'b0, stallD}, {1'b0, s && !pc});
    check("flushD", {1'b0, flushD}, {1'b0, pc});
    check("flushE", {1'b0, flushE}, {1'b0, pc || s});
    check("busy",   {1'b0, busy},   {1'b0, infl.size() != 0});
    pop_fwd();
    fq_a.push_back(iss ? fsel(h1, r1) : 2'b00);
    fq_b.push_back(iss ? fsel(h2, r2) : 2'b00);
    stalled = s && !pc;
    @(posedge clk);
    foreach (infl[i]) begin
      if (pc && infl[i].age == WB-1) continue;
      if (infl[i].age - 1 > 0) nq.push_back('{infl[i].rd, infl[i].ld, infl[i].age - 1});
    end
    if (iss && rw && rd != 0) nq.push_back('{rd, isld, WB-1});
    infl = nq;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; validD = 0; PCSrcM = 0; useRs1D = 0; useRs2D = 0; regWriteD = 0;
    mem2regD = 0; rs1D = 0; rs2D = 0; rdD = 0;
    #1;
    check("rst_stall", {stallF, stallD}, 2'b00);
    check("rst_flush", {flushD, flushE}, 2'b00);
    check("rst_busy",  {1'b0, busy}, 2'b00);
    pop_fwd();
    @(posedge clk);
    infl.delete(); fq_a.delete(); fq_b.delete();
    fq_a.push_back(2'b00); fq_b.push_back(2'b00);
  endtask

  task automatic nop();
    bit st;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
  endtask

  task automatic wr(input logic [RS-1:0] rd, input bit isld);
    bit st;
    step(1, 0, 0, 0, 0, rd, 1, isld, 0, st);
  endtask

  // Hold the D instruction until it issues; compare stall cycles to the expected count.
  task automatic consume(input string tag, input logic [RS-1:0] r1, input bit u1,
                         input logic [RS-1:0] r2, input bit u2, input int exp_stalls);
    bit st;
    int n = 0;
    do begin
      step(1, r1, u1, r2, u2, 0, 0, 0, 0, st);
      if (st) n++;
    end while (st && n < 8);
    check({tag, "_stalls"}, 2'(n), 2'(exp_stalls));
  endtask

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  initial begin
    bit st;
    do_reset();
    do_reset();

    wr(5, 0);
    consume("fwd_e", 5, 1, 0, 0, FWD ? 0 : 2);
    if (FWD) check("fwd_e_sel", forwardAE, 2'b10);
    nop(); nop(); nop();

    wr(6, 1);
    consume("load_use", 0, 0, 6, 1, FWD ? 1 : 2);
    if (FWD) check("load_use_sel", forwardBE, 2'b01);
    nop(); nop(); nop();

    wr(7, 0); nop();
    consume("fwd_w", 7, 1, 7, 1, FWD ? 0 : 1);
    nop(); nop(); nop();

    wr(0, 0);
    check("x0_busy", {1'b0, busy}, 2'b00);
    consume("x0", 0, 1, 0, 1, 0);
    nop();

    wr(8, 1); wr(8, 0);
    consume("waw", 8, 1, 0, 0, FWD ? 0 : 2);
    nop(); nop(); nop();

    wr(9, 1); wr(9, 0);
    step(1, 9, 1, 9, 1, 0, 0, 0, 1, st);
    check("flush_nostall", {1'b0, st}, 2'b00);
    consume("post_flush", 9, 1, 0, 0, 0);
    nop(); nop(); nop();

    wr(10, 0); wr(11, 1);
    do_reset();
    check("rst_busy_after", {1'b0, busy}, 2'b00);
    consume("post_rst", 10, 1, 11, 1, 0);
    nop(); nop();

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom), 5'($urandom_range(0, 5)), 1'($urandom), 5'($urandom_range(0, 5)),
           1'($urandom), 5'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), st);
    end
    nop(); nop(); nop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
